// File: rtl/la_adder_4.sv
`default_nettype none
// ============================================================================
//  Module      : la_adder_4
//  Description : 4-bit carry-lookahead adder with registered sum, carry-out
//                and group-propagate outputs. All carries are flat
//                sum-of-products terms with no ripple path. Cout and Pout
//                let instances be cascaded into a wider block-lookahead adder.
//                Optional macro LA_ADDER4_IN_REG_EN adds an input register
//                stage in front of the lookahead logic (2-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module la_adder_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       Pout
);

    // Operands as seen by the lookahead logic
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic       w_cin;

`ifdef LA_ADDER4_IN_REG_EN
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_cin;

    // Input stage: capture operands every cycle, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= A;
            r_b   <= B;
            r_cin <= Cin;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = A;
    assign w_b   = B;
    assign w_cin = Cin;
`endif

    // Per-bit propagate / generate
    logic [3:0] w_p;
    logic [3:0] w_g;

    assign w_p = w_a ^ w_b;
    assign w_g = w_a & w_b;

    // Flat two-level carries; every carry depends only on p, g and Cin
    logic w_c0;
    logic w_c1;
    logic w_c2;
    logic w_c3;
    logic w_c4;
    logic w_grp_g;
    logic w_grp_p;

    assign w_c0 = w_cin;

    assign w_c1 = w_g[0]
                | (w_p[0] & w_c0);

    assign w_c2 = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & w_c0);

    assign w_c3 = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c0);

    // Group generate/propagate for block-level lookahead
    assign w_grp_g = w_g[3]
                   | (w_p[3] & w_g[2])
                   | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign w_grp_p = w_p[3] & w_p[2] & w_p[1] & w_p[0];

    // c4 expands to the five product terms; written via G and P to share them
    assign w_c4 = w_grp_g | (w_grp_p & w_c0);

    logic [3:0] w_sum;

    assign w_sum = w_p ^ {w_c3, w_c2, w_c1, w_c0};

    // Output stage: reset has priority, otherwise capture a result every cycle
    logic [3:0] r_s;
    logic       r_cout;
    logic       r_pout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= 4'd0;
            r_cout <= 1'b0;
            r_pout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c4;
            r_pout <= w_grp_p;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign Pout = r_pout;

endmodule
`default_nettype wire

// File: tb/tb_la_adder_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_adder_4
//  Description : Self-checking bench for la_adder_4. Directed vector table,
//                hand-written reset/back-to-back sequence, exhaustive sweep
//                and random stimulus against an arithmetic reference model.
//                Honours LA_ADDER4_IN_REG_EN for the 2-cycle latency build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_adder_4;

`ifdef LA_ADDER4_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       Pout;

    int checks;
    int failures;

    la_adder_4 dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .Pout (Pout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, result packed as {Pout, Cout, S}
    function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int         t;
        logic [4:0] t5;
        logic       p;
        t  = int'(a) + int'(b) + int'(cin);
        t5 = t[4:0];
        p  = ((a ^ b) == 4'hF);
        return {p, t5[4], t5[3:0]};
    endfunction

    // Model state: expected output after the latest edge and the in-flight value
    logic [5:0] m_out;
    logic [5:0] m_mid;
    logic       m_valid;

    task automatic check_out(input string name, input logic [3:0] es, input logic ec, input logic ep);
        checks++;
        if (S !== es || Cout !== ec || Pout !== ep) begin
            failures++;
            $display("FAIL %s: got S=%0d Cout=%0d Pout=%0d, expected S=%0d Cout=%0d Pout=%0d (A=%0d B=%0d Cin=%0d rst=%0d)",
                     name, S, Cout, Pout, es, ec, ep, A, B, Cin, rst);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, compare against it
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic r);
        logic [5:0] f;
        A   = a;
        B   = b;
        Cin = cin;
        rst = r;
        f   = ref_add(a, b, cin);
        @(posedge clk);
        if (LAT == 1) begin
            m_out = r ? 6'd0 : f;
        end else begin
            m_out = r ? 6'd0 : m_mid;
            m_mid = r ? 6'd0 : f;
        end
        if (r) m_valid = 1'b1;
        #1;
        if (m_valid) check_out("model", m_out[3:0], m_out[4], m_out[5]);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       r;
        logic [3:0] s;
        logic       cout;
        logic       pout;
    } vec_t;

    vec_t tbl[8];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       r;
        logic       chk;
        logic [3:0] s;
        logic       cout;
        logic       pout;
    } seq_t;

    seq_t seq[5];

    initial begin
        checks   = 0;
        failures = 0;
        m_out    = 6'd0;
        m_mid    = 6'd0;
        m_valid  = 1'b0;
        A = 4'd0; B = 4'd0; Cin = 1'b0; rst = 1'b1;

        //          a      b      cin   rst   s      cout  pout
        tbl[0] = '{4'd9,  4'd9,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0};
        tbl[1] = '{4'd9,  4'd9,  1'b1, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[2] = '{4'd5,  4'd10, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1};
        tbl[3] = '{4'd5,  4'd10, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1};
        tbl[4] = '{4'd15, 4'd1,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[5] = '{4'd8,  4'd8,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[6] = '{4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0};
        tbl[7] = '{4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0};

        // Back-to-back with mid-stream reset; expectation is the output after each edge
`ifdef LA_ADDER4_IN_REG_EN
        seq[0] = '{4'd3,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        seq[1] = '{4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0};
        seq[2] = '{4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0};
        seq[3] = '{4'd7,  4'd8,  1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
        seq[4] = '{4'd7,  4'd8,  1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
`else
        seq[0] = '{4'd3,  4'd4,  1'b0, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0};
        seq[1] = '{4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0};
        seq[2] = '{4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0};
        seq[3] = '{4'd7,  4'd8,  1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
        seq[4] = '{4'd7,  4'd8,  1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
`endif

        // Directed table: hold each vector until it reaches the outputs
        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].r ? 2 : LAT) apply(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].r);
            check_out($sformatf("table[%0d]", i), tbl[i].s, tbl[i].cout, tbl[i].pout);
        end

        // Back-to-back and mid-stream reset
        for (int i = 0; i < 5; i++) begin
            apply(seq[i].a, seq[i].b, seq[i].cin, seq[i].r);
            if (seq[i].chk) check_out($sformatf("b2b[%0d]", i), seq[i].s, seq[i].cout, seq[i].pout);
        end

        // Exhaustive sweep, one combination per cycle
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    apply(4'(a), 4'(b), 1'(c), 1'b0);
                end
            end
        end

        // Random stimulus with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
